// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL-lock-qualified core reset controller.
package pll_rst_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned LOST_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Counter width covering the longer of the two qualification phases, at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// N-stage synchronizer of a constant 1, cleared asynchronously by clr_n.
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], 1'b1};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// Holds the core in reset until PLL lock has been stable for LOCK_CYCLES and
// then HOLD_CYCLES more; any lock drop reasserts reset immediately.
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic [STATE_W-1:0]    state_dbg
);

  localparam int unsigned         CNT_W     = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0]    LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LOST_CNT_W-1:0] LOST_MAX = '1;

  logic                  arst_n;
  logic                  locked_s;
  state_e                state;
  state_e                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  run_nxt;
  logic                  run_seen;
  logic                  run_seen_nxt;
  logic [LOST_CNT_W-1:0] lost_nxt;

  // Losing lock clears everything in the core reset path without needing a clock.
  assign arst_n = rst_n & locked;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .clr_n (arst_n),
    .q     (locked_s)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // A loss is only counted once per RUN episode, on the first edge that sees lock gone.
  always_comb begin
    run_nxt      = (state_nxt == RUN);
    run_seen_nxt = run_seen;
    lost_nxt     = lock_lost_cnt;
    if (!locked_s && run_seen) begin
      run_seen_nxt = 1'b0;
      if (lock_lost_cnt != LOST_MAX) lost_nxt = lock_lost_cnt + LOST_CNT_W'(1);
    end else if (run_nxt && (state != RUN)) begin
      run_seen_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      sys_rst_n <= run_nxt;
      ready     <= run_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_seen      <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      run_seen      <= run_seen_nxt;
      lock_lost_cnt <= lost_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench: stimulus queues expected sys_rst_n rise events, monitors check them.
module tb_pll_reset_ctrl;

  typedef struct {
    int edges;
    int lost;
  } exp_t;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n = 1'b1;
  logic       locked = 1'b0;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic [1:0] state_dbg;

  logic       rst2_n = 1'b1;
  logic       locked2 = 1'b0;
  logic       sys_rst2_n;
  logic       ready2;
  logic [7:0] lost2;
  logic [1:0] state2;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   edge2 = 0;
  int   lost_model = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  pll_reset_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt),
    .state_dbg     (state_dbg)
  );

  pll_reset_ctrl #(
    .LOCK_CYCLES (1),
    .HOLD_CYCLES (1),
    .SYNC_STAGES (2)
  ) u_dut_min (
    .clk           (clk),
    .rst_n         (rst2_n),
    .locked        (locked2),
    .sys_rst_n     (sys_rst2_n),
    .ready         (ready2),
    .lock_lost_cnt (lost2),
    .state_dbg     (state2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
    else         clk = 1'b0;
  end

  always @(posedge clk) begin
    edge_cnt++;
    edge2++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge sys_rst_n) begin
    #1;
    if (q1.size() == 0) begin
      chk("dut1_unexpected_rise_edge", edge_cnt, -1);
    end else begin
      e1 = q1.pop_front();
      chk("dut1_rise_edge", edge_cnt, e1.edges);
      chk("dut1_rise_lost", int'(lock_lost_cnt), e1.lost);
      chk("dut1_rise_ready", int'(ready), 1);
      chk("dut1_rise_state", int'(state_dbg), 3);
    end
  end

  always @(posedge sys_rst2_n) begin
    #1;
    if (q2.size() == 0) begin
      chk("dut2_unexpected_rise_edge", edge2, -1);
    end else begin
      e2 = q2.pop_front();
      chk("dut2_rise_edge", edge2, e2.edges);
      chk("dut2_rise_lost", int'(lost2), e2.lost);
      chk("dut2_rise_ready", int'(ready2), 1);
      chk("dut2_rise_state", int'(state2), 3);
    end
  end

  task automatic expect_rise(input int dut, input int edges, input int lost);
    exp_t e;
    int   n;
    e.edges = edges;
    e.lost  = lost;
    if (dut == 1) q1.push_back(e);
    else          q2.push_back(e);
    for (int i = 0; i < edges + 20; i++) begin
      @(negedge clk);
      n = (dut == 1) ? q1.size() : q2.size();
      if (n == 0) break;
    end
    n = (dut == 1) ? q1.size() : q2.size();
    if (n != 0) begin
      chk("rise_timeout_pending", n, 0);
      if (dut == 1) q1.delete();
      else          q2.delete();
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_state"}, int'(state_dbg), 0);
  endtask

  initial begin
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    #1;
    chk_reset1("por");
    chk("por_lost", int'(lock_lost_cnt), 0);
    chk("por2_sys_rst_n", int'(sys_rst2_n), 0);

    // Lock present but master reset held: nothing may advance.
    locked = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset1("rst_held");
    locked = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset1("no_lock");

    // Lock qualifies partway, then a 1-unit glitch restarts qualification.
    locked   = 1'b1;
    edge_cnt = 0;
    repeat (10) @(negedge clk);
    chk("pre_glitch_state", int'(state_dbg), 1);
    chk("pre_glitch_sys_rst_n", int'(sys_rst_n), 0);
    locked = 1'b0;
    #1;
    chk_reset1("glitch");
    locked   = 1'b1;
    edge_cnt = 0;
    expect_rise(1, 27, 0);
    chk("after_glitch_lost", int'(lock_lost_cnt), 0);

    // Loss in RUN with the PLL clock stopped: reset must drop with no edge.
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    locked = 1'b0;
    #1;
    chk_reset1("loss_noclk");
    chk("loss_noclk_lost", int'(lock_lost_cnt), 0);
    #20;
    locked   = 1'b1;
    edge_cnt = 0;
    clk_run  = 1'b1;
    @(posedge clk);
    #1;
    chk("loss_first_edge_lost", int'(lock_lost_cnt), 1);
    expect_rise(1, 27, 1);

    // Loss from RUN, relock, then master reset pulsed during HOLD.
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked   = 1'b1;
    edge_cnt = 0;
    repeat (21) @(negedge clk);
    chk("hold_state", int'(state_dbg), 2);
    chk("hold_sys_rst_n", int'(sys_rst_n), 0);
    chk("hold_lost", int'(lock_lost_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk_reset1("rst_in_hold");
    chk("rst_in_hold_lost", int'(lock_lost_cnt), 0);
    #1;
    rst_n    = 1'b1;
    edge_cnt = 0;
    expect_rise(1, 27, 0);

    // Repeated RUN-then-loss episodes drive the loss counter into saturation.
    lost_model = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked     = 1'b1;
      edge_cnt   = 0;
      lost_model = (lost_model < 255) ? lost_model + 1 : 255;
      expect_rise(1, 27, lost_model);
    end
    chk("sat_lost", int'(lock_lost_cnt), 255);
    chk("sat_ready", int'(ready), 1);

    // Minimum qualification lengths.
    @(negedge clk);
    chk("min_idle_sys_rst_n", int'(sys_rst2_n), 0);
    locked2 = 1'b1;
    edge2   = 0;
    expect_rise(2, 5, 0);
    @(negedge clk);
    locked2 = 1'b0;
    #1;
    chk("min_drop_sys_rst_n", int'(sys_rst2_n), 0);
    @(negedge clk);
    locked2 = 1'b1;
    edge2   = 0;
    expect_rise(2, 5, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
